// File: rtl/uart_boot_loader_pkg.sv
// Shared types and constants for the UART boot loader: FSM states, default
// acknowledge byte and the number of byte lanes per program word.
package uart_boot_loader_pkg;

    typedef enum logic [1:0] {
        ST_HDR,
        ST_DATA,
        ST_ACK,
        ST_RUN
    } state_t;

    localparam logic [7:0] ACK_DEFAULT    = 8'hAA;
    localparam int         BYTES_PER_WORD = 4;

endpackage

// File: rtl/uart_boot_loader_byte_assembler.sv
// Pops bytes from a first-word-fall-through RX buffer (one pop, then one gap
// cycle) and shifts them little-endian into 32-bit words.
module uart_boot_loader_byte_assembler
    import uart_boot_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [7:0]  rdata,
    input  logic        rx_ready,
    output logic        next,
    output logic [31:0] word,
    output logic        word_valid
);
    logic        gap_reg;
    logic [1:0]  byte_cnt_reg;
    logic [23:0] shift_reg;

    // Buffer status lags a pop by one cycle, so the cycle after a pop is skipped.
    assign next       = enable && rx_ready && !gap_reg && !rst;
    assign word       = {rdata, shift_reg};
    assign word_valid = next && (byte_cnt_reg == 2'(BYTES_PER_WORD - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gap_reg      <= 1'b0;
            byte_cnt_reg <= 2'd0;
            shift_reg    <= 24'd0;
        end else begin
            gap_reg <= next;
            if (next) begin
                shift_reg    <= {rdata, shift_reg[23:8]};
                byte_cnt_reg <= byte_cnt_reg + 2'd1;
            end
        end
    end

endmodule

// File: rtl/uart_boot_loader.sv
// Boot sequencer: receives a length-prefixed program over UART into program RAM,
// acknowledges once, releases the core and then passes the UART streams through.
module uart_boot_loader
    import uart_boot_loader_pkg::*;
#(
    parameter int         MEM = 19,
    parameter logic [7:0] ACK = ACK_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [7:0]     rdata,
    input  logic           rx_ready,
    output logic           next,
    output logic [7:0]     sdata,
    output logic           tx_ready,
    output logic           prog_we,
    output logic [MEM-3:0] prog_addr,
    output logic [31:0]    prog_din,
    output logic           core_rstn,
    output logic [7:0]     core_rdata,
    output logic           core_rx_ready,
    input  logic           core_next,
    input  logic [7:0]     core_sdata,
    input  logic           core_tx_ready
);
    localparam logic [31:0] DEPTH = 32'd1 << (MEM - 2);

    state_t         state_reg;
    logic [31:0]    count_reg;
    logic [31:0]    index_reg;
    logic           slot_reg;
    logic           prog_we_reg;
    logic [MEM-3:0] prog_addr_reg;
    logic [31:0]    prog_din_reg;
    logic           tx_ready_reg;
    logic [7:0]     sdata_reg;
    logic           core_rstn_reg;

    logic           asm_enable;
    logic           asm_next;
    logic [31:0]    word;
    logic           word_valid;

    assign asm_enable = (state_reg == ST_HDR) || (state_reg == ST_DATA);

    uart_boot_loader_byte_assembler u_asm (
        .clk        (clk),
        .rst        (rst),
        .enable     (asm_enable),
        .rdata      (rdata),
        .rx_ready   (rx_ready),
        .next       (asm_next),
        .word       (word),
        .word_valid (word_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_HDR;
            count_reg     <= 32'd0;
            index_reg     <= 32'd0;
            slot_reg      <= 1'b0;
            prog_we_reg   <= 1'b0;
            prog_addr_reg <= '0;
            prog_din_reg  <= 32'd0;
            tx_ready_reg  <= 1'b0;
            sdata_reg     <= 8'd0;
            core_rstn_reg <= 1'b0;
        end else begin
            prog_we_reg  <= 1'b0;
            tx_ready_reg <= 1'b0;
            slot_reg     <= 1'b0;
            case (state_reg)
                ST_HDR: begin
                    if (word_valid) begin
                        count_reg <= word;
                        index_reg <= 32'd0;
                        if (word == 32'd0) begin
                            state_reg    <= ST_ACK;
                            tx_ready_reg <= 1'b1;
                            sdata_reg    <= ACK;
                        end else begin
                            state_reg <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    // Words beyond the RAM depth are consumed without a write.
                    if (word_valid) begin
                        prog_we_reg   <= (index_reg < DEPTH);
                        prog_addr_reg <= index_reg[MEM-3:0];
                        prog_din_reg  <= word;
                        index_reg     <= index_reg + 32'd1;
                        slot_reg      <= 1'b1;
                    end
                    if (slot_reg && (index_reg == count_reg)) begin
                        state_reg    <= ST_ACK;
                        tx_ready_reg <= 1'b1;
                        sdata_reg    <= ACK;
                    end
                end
                ST_ACK: begin
                    state_reg     <= ST_RUN;
                    core_rstn_reg <= 1'b1;
                end
                default: begin
                    state_reg <= ST_RUN;
                end
            endcase
        end
    end

    assign prog_we       = prog_we_reg;
    assign prog_addr     = prog_addr_reg;
    assign prog_din      = prog_din_reg;
    assign core_rstn     = core_rstn_reg;

    // Once the core is released the loader is transparent to both byte streams.
    assign next          = core_rstn_reg ? core_next     : asm_next;
    assign sdata         = core_rstn_reg ? core_sdata    : sdata_reg;
    assign tx_ready      = core_rstn_reg ? core_tx_ready : tx_ready_reg;
    assign core_rdata    = core_rstn_reg ? rdata         : 8'd0;
    assign core_rx_ready = core_rstn_reg && rx_ready;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Self-checking bench: two loader instances (full-size and 4-word RAM) share one
// modelled RX buffer; recorded writes/ACK/timing are compared to a stream model.
module tb_uart_boot_loader;
    localparam int MEM_BIG   = 19;
    localparam int MEM_SMALL = 4;

    logic clk = 1'b0;
    logic rst;
    logic [7:0] rdata;
    logic rx_ready;
    logic core_next;
    logic [7:0] core_sdata;
    logic core_tx_ready;

    logic next, tx_ready, prog_we, core_rstn, core_rx_ready;
    logic [7:0] sdata, core_rdata;
    logic [MEM_BIG-3:0] prog_addr;
    logic [31:0] prog_din;

    logic s_next, s_tx_ready, s_prog_we, s_core_rstn, s_core_rx_ready;
    logic [7:0] s_sdata, s_core_rdata;
    logic [MEM_SMALL-3:0] s_prog_addr;
    logic [31:0] s_prog_din;

    always #5 clk = ~clk;

    uart_boot_loader #(.MEM(MEM_BIG)) dut (
        .clk(clk), .rst(rst), .rdata(rdata), .rx_ready(rx_ready), .next(next),
        .sdata(sdata), .tx_ready(tx_ready), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_din(prog_din), .core_rstn(core_rstn), .core_rdata(core_rdata),
        .core_rx_ready(core_rx_ready), .core_next(core_next), .core_sdata(core_sdata),
        .core_tx_ready(core_tx_ready)
    );

    uart_boot_loader #(.MEM(MEM_SMALL)) dut_small (
        .clk(clk), .rst(rst), .rdata(rdata), .rx_ready(rx_ready), .next(s_next),
        .sdata(s_sdata), .tx_ready(s_tx_ready), .prog_we(s_prog_we), .prog_addr(s_prog_addr),
        .prog_din(s_prog_din), .core_rstn(s_core_rstn), .core_rdata(s_core_rdata),
        .core_rx_ready(s_core_rx_ready), .core_next(core_next), .core_sdata(core_sdata),
        .core_tx_ready(core_tx_ready)
    );

    logic [7:0]  stream[$];
    logic [7:0]  rxq[$];
    logic [7:0]  popped[$];
    logic [31:0] wa_b[$], wd_b[$], wa_s[$], wd_s[$];
    int ack_cnt_b, ack_cyc_b, rstn_cyc_b;
    int ack_cnt_s, ack_cyc_s, rstn_cyc_s;
    logic [7:0] ack_dat_b, ack_dat_s;
    int cyc, last_pop_cyc, hold_cnt, consec_cnt, next_diff;
    bit sparse, prev_next;
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_rx();
        if (hold_cnt > 0) begin
            hold_cnt--;
            rx_ready = 1'b0;
            rdata    = 8'($urandom);
        end else if (rxq.size() > 0) begin
            rx_ready = 1'b1;
            rdata    = rxq[0];
        end else begin
            rx_ready = 1'b0;
            rdata    = 8'($urandom);
        end
    endtask

    task automatic clear_rec();
        popped.delete();
        wa_b.delete(); wd_b.delete(); wa_s.delete(); wd_s.delete();
        ack_cnt_b = 0; ack_cyc_b = -1; rstn_cyc_b = -1; ack_dat_b = 8'h00;
        ack_cnt_s = 0; ack_cyc_s = -1; rstn_cyc_s = -1; ack_dat_s = 8'h00;
        last_pop_cyc = -1; consec_cnt = 0; next_diff = 0; prev_next = 1'b0;
        hold_cnt = 0;
        rxq = stream;
    endtask

    // One clock: observe at the falling edge, update the buffer model after the rising edge.
    task automatic tick();
        bit pop;
        @(negedge clk);
        pop = next;
        if (next) begin
            if (prev_next) consec_cnt++;
            popped.push_back(rdata);
            last_pop_cyc = cyc;
        end
        if (s_next !== next) next_diff++;
        prev_next = next;
        if (prog_we)   begin wa_b.push_back(32'(prog_addr));   wd_b.push_back(prog_din);   end
        if (s_prog_we) begin wa_s.push_back(32'(s_prog_addr)); wd_s.push_back(s_prog_din); end
        if (tx_ready && !core_rstn)     begin ack_cnt_b++; ack_cyc_b = cyc; ack_dat_b = sdata;   end
        if (s_tx_ready && !s_core_rstn) begin ack_cnt_s++; ack_cyc_s = cyc; ack_dat_s = s_sdata; end
        if (core_rstn && rstn_cyc_b < 0)   rstn_cyc_b = cyc;
        if (s_core_rstn && rstn_cyc_s < 0) rstn_cyc_s = cyc;
        @(posedge clk);
        #1;
        cyc++;
        if (pop) begin
            if (rxq.size() > 0) rxq.delete(0);
            if (sparse) hold_cnt = $urandom_range(0, 20);
        end
        drive_rx();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rx_ready = 1'b0;
        core_next = 1'b0; core_sdata = 8'h00; core_tx_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        clear_rec();
        drive_rx();
    endtask

    task automatic make_stream(input logic [31:0] n);
        stream.delete();
        for (int i = 0; i < 4; i++) stream.push_back(n[8*i +: 8]);
        for (int i = 0; i < int'(n); i++)
            for (int b = 0; b < 4; b++) stream.push_back(8'($urandom));
    endtask

    // Reference: header is a little-endian word count, then N little-endian words;
    // only the first 'depth' words land in RAM, at consecutive addresses from 0.
    task automatic compare_writes(input string tag, input int depth,
                                  input logic [31:0] ga[$], input logic [31:0] gd[$]);
        logic [31:0] n_words, w;
        int n_exp;
        n_words = {stream[3], stream[2], stream[1], stream[0]};
        n_exp = (int'(n_words) < depth) ? int'(n_words) : depth;
        check({tag, " write count"}, 64'(ga.size()), 64'(n_exp));
        for (int i = 0; i < n_exp && i < ga.size(); i++) begin
            w = {stream[4*i+7], stream[4*i+6], stream[4*i+5], stream[4*i+4]};
            check($sformatf("%s addr[%0d]", tag, i), 64'(ga[i]), 64'(i));
            check($sformatf("%s data[%0d]", tag, i), 64'(gd[i]), 64'(w));
        end
    endtask

    task automatic run_load(input string tag, input bit sp, input int abort_after);
        int budget;
        int mm;
        int exp_lat;
        sparse = sp;
        do_reset();
        budget = 0;
        if (abort_after > 0) begin
            while (popped.size() < abort_after && budget < 1000) begin tick(); budget++; end
            #2 rst = 1'b1;
            #1;
            check({tag, " async next"},      64'(next),      64'(0));
            check({tag, " async prog_we"},   64'(prog_we),   64'(0));
            check({tag, " async tx_ready"},  64'(tx_ready),  64'(0));
            check({tag, " async core_rstn"}, 64'(core_rstn), 64'(0));
            check({tag, " async prog_din"},  64'(prog_din),  64'(0));
            check({tag, " ack before rst"},  64'(ack_cnt_b), 64'(0));
            @(posedge clk);
            #1;
            rst = 1'b0;
            clear_rec();
            drive_rx();
        end
        while (!(core_rstn && s_core_rstn) && budget < 4000) begin tick(); budget++; end
        repeat (3) tick();
        check({tag, " load finished"}, 64'({core_rstn, s_core_rstn}), 64'(2'b11));
        compare_writes({tag, " big"},   1 << (MEM_BIG - 2),   wa_b, wd_b);
        compare_writes({tag, " small"}, 1 << (MEM_SMALL - 2), wa_s, wd_s);
        check({tag, " ack count"},   64'(ack_cnt_b), 64'(1));
        check({tag, " ack data"},    64'(ack_dat_b), 64'(8'hAA));
        check({tag, " s ack count"}, 64'(ack_cnt_s), 64'(1));
        exp_lat = ({stream[3], stream[2], stream[1], stream[0]} == 32'd0) ? 1 : 2;
        check({tag, " ack latency"},  64'(ack_cyc_b - last_pop_cyc), 64'(exp_lat));
        check({tag, " rstn latency"}, 64'(rstn_cyc_b - ack_cyc_b),   64'(1));
        check({tag, " s rstn latency"}, 64'(rstn_cyc_s - ack_cyc_s), 64'(1));
        check({tag, " bytes popped"}, 64'(popped.size()), 64'(stream.size()));
        mm = 0;
        for (int i = 0; i < popped.size() && i < stream.size(); i++)
            if (popped[i] !== stream[i]) mm++;
        check({tag, " byte order"},     64'(mm),         64'(0));
        check({tag, " next back2back"}, 64'(consec_cnt), 64'(0));
        check({tag, " next agree"},     64'(next_diff),  64'(0));
        $display("[TB] %s: %0d bytes, %0d writes, ack at cycle %0d", tag, popped.size(), wa_b.size(), ack_cyc_b);
    endtask

    initial begin
        cyc = 0;
        sparse = 1'b0;
        stream.delete();
        rst = 1'b1;
        rdata = 8'h5A; rx_ready = 1'b1;
        core_next = 1'b1; core_sdata = 8'h41; core_tx_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset next",          64'(next),          64'(0));
        check("reset tx_ready",      64'(tx_ready),      64'(0));
        check("reset sdata",         64'(sdata),         64'(0));
        check("reset prog_we",       64'(prog_we),       64'(0));
        check("reset prog_addr",     64'(prog_addr),     64'(0));
        check("reset prog_din",      64'(prog_din),      64'(0));
        check("reset core_rstn",     64'(core_rstn),     64'(0));
        check("reset core_rx_ready", 64'(core_rx_ready), 64'(0));
        check("reset core_rdata",    64'(core_rdata),    64'(0));
        $display("[TB] reset values checked");

        stream = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h05, 8'h00, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
        run_load("nominal", 1'b0, 0);
        run_load("sparse", 1'b1, 0);
        make_stream(32'd0);
        run_load("empty", 1'b0, 0);
        make_stream(32'd6);
        run_load("overflow", 1'b1, 0);
        for (int k = 0; k < 3; k++) begin
            make_stream(32'($urandom_range(1, 5)));
            run_load($sformatf("random%0d", k), k[0], 0);
        end
        stream = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h05, 8'h00, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
        run_load("reset mid-load", 1'b0, 6);

        for (int k = 0; k < 5; k++) begin
            if (k == 0) begin
                core_next = 1'b1; core_sdata = 8'h41; core_tx_ready = 1'b1; rx_ready = 1'b1; rdata = 8'h5A;
            end else begin
                core_next = 1'($urandom); core_sdata = 8'($urandom); core_tx_ready = 1'($urandom);
                rx_ready = 1'($urandom); rdata = 8'($urandom);
            end
            #2;
            check("pass next",          64'(next),          64'(core_next));
            check("pass sdata",         64'(sdata),         64'(core_sdata));
            check("pass tx_ready",      64'(tx_ready),      64'(core_tx_ready));
            check("pass core_rdata",    64'(core_rdata),    64'(rdata));
            check("pass core_rx_ready", 64'(core_rx_ready), 64'(rx_ready));
            $display("[TB] pass-through rdata=%02h sdata=%02h next=%0b", rdata, core_sdata, core_next);
            @(posedge clk);
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_boot_loader.md
Name: uart_boot_loader

Overview:
- Boot sequencer between uart_rx_with_buf / uart_tx_with_buf, ram_prog and core.
- After reset it holds the core in reset and receives a length-prefixed program over UART.
- It writes the program word-by-word into ram_prog, sends one acknowledge byte, then releases the core.
- From then on it passes the UART byte streams straight through to the core.

Parameters:
- MEM, 19, byte-address width; program word address width is MEM-2 (depth 2^(MEM-2) words).
- ACK, 8'hAA, byte transmitted once when loading completes.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- rdata  in  8  head byte of RX buffer
- rx_ready  in  1  RX buffer non-empty; rdata valid
- next  out  1  one-cycle pop of RX buffer head
- sdata  out  8  byte to TX buffer
- tx_ready  out  1  one-cycle push of sdata into TX buffer
- prog_we  out  1  program RAM write enable
- prog_addr  out  MEM-2  program RAM word address
- prog_din  out  32  program RAM write data
- core_rstn  out  1  active-low reset to core; 0 until loading completes
- core_rdata  out  8  RX byte seen by core
- core_rx_ready  out  1  RX valid seen by core
- core_next  in  1  core's RX pop request
- core_sdata  in  8  core's TX byte
- core_tx_ready  in  1  core's TX push

Behaviour:
- Clock and reset: one clock; rst is asynchronous, active-high.
- Reset values: state=HDR, all byte/word counters 0, next=0, tx_ready=0, prog_we=0, prog_addr=0, prog_din=0, sdata=0, core_rstn=0, core_rx_ready=0, core_rdata=0.
- RX handshake (FWFT):
  - A byte is consumed in a cycle where rx_ready=1; the loader registers rdata and asserts next for exactly that cycle.
  - The cycle after any pop is a mandatory gap (next=0, rx_ready ignored), because the buffer status updates one cycle late. Maximum intake is 1 byte per 2 cycles.
- Byte order: little-endian. The first byte received is bits [7:0].
- HDR:
  - Collect 4 bytes into a 32-bit word count N (stored in a 32-bit register).
  - After the 4th byte: if N==0 go to ACK, else go to DATA with word index 0.
- DATA:
  - Collect 4 bytes into a word.
  - The cycle after the 4th byte is captured: prog_we=1 for one cycle, prog_din=word, prog_addr=index[MEM-3:0].
  - The index then increments.
  - Words with index >= 2^(MEM-2) are consumed but not written (prog_we stays 0); no wrap.
  - When index reaches N, go to ACK the cycle after the last write slot.
- ACK:
  - tx_ready=1, sdata=ACK for exactly one cycle.
  - Next state RUN. No TX back-pressure exists; the TX buffer absorbs it.
- RUN (terminal until rst):
  - core_rstn=1, registered; it rises the cycle after ACK.
  - Combinational pass-through: next=core_next, core_rdata=rdata, core_rx_ready=rx_ready, sdata=core_sdata, tx_ready=core_tx_ready.
- Before RUN:
  - core_rx_ready=0; core_next, core_sdata and core_tx_ready are ignored.
  - The loader's own next/tx_ready/sdata drive the buffers.
- Simultaneous events:
  - prog_we and a new byte capture may occur in the same cycle; they are independent.
  - In the final DATA write cycle, no byte is popped.
- Reset mid-operation:
  - Immediate return to HDR with counters cleared and core_rstn=0.
  - Program RAM contents already written are not cleared.
  - Bytes left in the RX buffer are not flushed; they are parsed as a new header.
- Arithmetic: the index comparison is a full 32-bit compare against N; the index counter is 32 bits.

Decomposition:
- Shared package: state encoding (HDR, DATA, ACK, RUN), ACK default, and the byte-lane constant 4 (bytes per word).
- One natural sub-module: byte_assembler (pop/gap handshake plus a 4-byte little-endian shift into a 32-bit word; outputs word_valid pulse). The FSM, address counter and UART mux stay in the top.

Test Plan:
- Nominal load: bytes 02 00 00 00, 13 05 00 00, 93 05 10 00 with rx_ready always high -> prog_we pulses twice: addr 0 data 0x00000513, addr 1 data 0x00100593. One ACK byte 0xAA. core_rstn rises one cycle after the ACK pulse. next is never high on consecutive cycles.
- Empty program: header 00 00 00 00 -> no prog_we; tx_ready pulses with 0xAA; core_rstn=1 two cycles after the 4th byte is captured.
- Sparse arrival: same 2-word program with rx_ready toggled pseudo-randomly (gaps of 0–20 cycles) -> identical writes and ACK; no byte lost or duplicated.
- Overflow, MEM=4 (depth 4): N=6 -> writes only at addr 0..3 with the first 4 words. Words 5–6 are consumed without a write; then ACK and RUN.
- Reset mid-load: assert rst after 6 bytes of a 2-word load, then resend the full stream -> outputs return to reset values asynchronously; the reload produces the correct writes; core_rstn stays 0 until the new ACK.
- Pass-through in RUN: drive core_next=1, core_sdata=0x41, core_tx_ready=1, rx_ready=1, rdata=0x5A -> next=1, sdata=0x41, tx_ready=1, core_rdata=0x5A, core_rx_ready=1 in the same cycle.
